// File: rtl/color_pkg.sv
// Shared codes, phase encoding and sequencer step for the colour front end.
package color_pkg;

  typedef enum logic [1:0] {
    PH_R    = 2'd0,
    PH_G    = 2'd1,
    PH_B    = 2'd2,
    PH_CALC = 2'd3
  } phase_e;

  // {S2,S3} filter-select codes
  localparam logic [1:0] SELECT_R   = 2'b00;
  localparam logic [1:0] SELECT_G   = 2'b11;
  localparam logic [1:0] SELECT_B   = 2'b01;
  localparam logic [1:0] SELECT_OFF = 2'b11;

  localparam logic [1:0] COLOR_NONE  = 2'd0;
  localparam logic [1:0] COLOR_RED   = 2'd1;
  localparam logic [1:0] COLOR_GREEN = 2'd2;
  localparam logic [1:0] COLOR_BLUE  = 2'd3;

  function automatic phase_e next_phase(input phase_e ph);
    case (ph)
      PH_R:    return PH_G;
      PH_G:    return PH_B;
      PH_B:    return PH_CALC;
      default: return PH_R;
    endcase
  endfunction

endpackage

// File: rtl/color_channel.sv
// One sensor channel: wave sync, gated edge counting, dominance classifier,
// frame stability filter and enable-change tracking.
module color_channel
  import color_pkg::*;
#(
  parameter int unsigned PH_W      = 11,
  parameter int unsigned PERIOD_US = 2000,
  parameter int unsigned SETTLE_US = 100,
  parameter int unsigned CNT_W     = 10,
  parameter int unsigned MIN_CNT   = 16,
  parameter int unsigned RATIO_SH  = 2,
  parameter int unsigned STABLE_N  = 2
) (
  input  logic               clkus,
  input  logic               rst_n,
  input  logic               wave,
  input  logic               en,
  input  phase_e             phase,
  input  logic [PH_W-1:0]    cnt,
  output logic [1:0]         color,
  output logic               color_valid,
  output logic [3*CNT_W-1:0] counts
);

  localparam int unsigned STAB_W = $clog2(STABLE_N + 1);

  typedef logic [CNT_W-1:0] cnt_t;

  logic [2:0]        sync_q, sync_d;
  cnt_t              r_q, r_d, g_q, g_d, b_q, b_d;
  logic [STAB_W-1:0] stab_q, stab_d;
  logic [1:0]        last_q, last_d, color_q, color_d, class_c;
  logic              valid_q, valid_d, frame_ok_q, frame_ok_d, en_prev_q, en_prev_d;
  logic              calc_c, calc_start_c, clear_c, frame_start_c, count_c, en_chg_c;

  // x wins only if its count minus the margin strictly beats both others
  function automatic logic dominates(input cnt_t x, input cnt_t y, input cnt_t z);
    cnt_t m;
    m = x - (x >> RATIO_SH);
    return (x >= CNT_W'(MIN_CNT)) && (m > y) && (m > z);
  endfunction

  always_comb begin
    calc_c        = (phase == PH_CALC);
    calc_start_c  = calc_c && (cnt == '0);
    clear_c       = calc_c && (cnt == PH_W'(PERIOD_US - 1));
    frame_start_c = (phase == PH_R) && (cnt == '0);
    en_chg_c      = en ^ en_prev_q;
    count_c       = sync_q[1] && !sync_q[2] && en && !calc_c && (cnt >= PH_W'(SETTLE_US));
  end

  always_comb begin
    class_c = COLOR_NONE;
    if (dominates(r_q, g_q, b_q))      class_c = COLOR_RED;
    else if (dominates(g_q, r_q, b_q)) class_c = COLOR_GREEN;
    else if (dominates(b_q, r_q, g_q)) class_c = COLOR_BLUE;
  end

  // sync pipe and saturating per-colour counters; clear beats a coincident edge
  always_comb begin
    sync_d = {sync_q[1:0], wave};
    r_d    = r_q;
    g_d    = g_q;
    b_d    = b_q;
    if (clear_c) begin
      r_d = '0;
      g_d = '0;
      b_d = '0;
    end else if (count_c) begin
      case (phase)
        PH_R:    if (r_q != '1) r_d = r_q + 1'b1;
        PH_G:    if (g_q != '1) g_d = g_q + 1'b1;
        PH_B:    if (b_q != '1) b_d = b_q + 1'b1;
        default: ;
      endcase
    end
  end

  // a frame whose enable moved is not classified; re-armed at each frame start
  always_comb begin
    stab_d     = stab_q;
    last_d     = last_q;
    color_d    = color_q;
    valid_d    = 1'b0;
    en_prev_d  = en;
    frame_ok_d = frame_ok_q;
    if (frame_start_c)  frame_ok_d = 1'b1;
    else if (en_chg_c)  frame_ok_d = 1'b0;
    if (calc_c && !en) begin
      color_d = COLOR_NONE;
      stab_d  = '0;
    end else if (calc_start_c && frame_ok_q && !en_chg_c) begin
      valid_d = 1'b1;
      if (class_c == last_q) begin
        if (stab_q < STAB_W'(STABLE_N)) stab_d = stab_q + 1'b1;
      end else begin
        stab_d = STAB_W'(1);
        last_d = class_c;
      end
      if (stab_d == STAB_W'(STABLE_N)) color_d = class_c;
    end
  end

  always_ff @(posedge clkus) begin
    if (!rst_n) begin
      sync_q     <= '0;
      r_q        <= '0;
      g_q        <= '0;
      b_q        <= '0;
      stab_q     <= '0;
      last_q     <= COLOR_NONE;
      color_q    <= COLOR_NONE;
      valid_q    <= 1'b0;
      frame_ok_q <= 1'b1;
      en_prev_q  <= 1'b0;
    end else begin
      sync_q     <= sync_d;
      r_q        <= r_d;
      g_q        <= g_d;
      b_q        <= b_d;
      stab_q     <= stab_d;
      last_q     <= last_d;
      color_q    <= color_d;
      valid_q    <= valid_d;
      frame_ok_q <= frame_ok_d;
      en_prev_q  <= en_prev_d;
    end
  end

  assign color       = color_q;
  assign color_valid = valid_q;
  assign counts      = {r_q, g_q, b_q};

endmodule

// File: rtl/color_classifier_array.sv
// Multi-channel colour sensor front end: shared R/G/B/CALC sequencer,
// filter-select and LED drive, per-channel classifiers and a debug count tap.
module color_classifier_array
  import color_pkg::*;
#(
  parameter int unsigned N_CH      = 2,
  parameter int unsigned PERIOD_US = 2000,
  parameter int unsigned SETTLE_US = 100,
  parameter int unsigned CNT_W     = 10,
  parameter int unsigned MIN_CNT   = 16,
  parameter int unsigned RATIO_SH  = 2,
  parameter int unsigned STABLE_N  = 2,
  localparam int unsigned DBG_W    = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic                 clkus,
  input  logic                 rst_n,
  input  logic [N_CH-1:0]      wave,
  input  logic [N_CH-1:0]      en,
  output logic [2*N_CH-1:0]    sel,
  output logic [N_CH-1:0]      led,
  output logic [2*N_CH-1:0]    color,
  output logic [N_CH-1:0]      color_valid,
  output logic [3*CNT_W-1:0]   raw_cnt,
  input  logic [DBG_W-1:0]     dbg_ch
);

  localparam int unsigned PH_W = $clog2(PERIOD_US);

  phase_e             phase_q, phase_d;
  logic [PH_W-1:0]    cnt_q, cnt_d;
  logic [2*N_CH-1:0]  sel_q, sel_d;
  logic [N_CH-1:0]    led_q, led_d;
  logic [3*CNT_W-1:0] raw_q, raw_d;
  logic [3*CNT_W-1:0] ch_cnt [N_CH];

  always_comb begin
    phase_d = phase_q;
    cnt_d   = cnt_q + 1'b1;
    if (cnt_q == PH_W'(PERIOD_US - 1)) begin
      cnt_d   = '0;
      phase_d = next_phase(phase_q);
    end
  end

  // filter select follows the phase one cycle late; CALC keeps the blue code
  always_comb begin
    led_d = en;
    sel_d = sel_q;
    for (int unsigned i = 0; i < N_CH; i++) begin
      if (!en[i]) begin
        sel_d[2*i +: 2] = SELECT_OFF;
      end else begin
        case (phase_q)
          PH_R:    sel_d[2*i +: 2] = SELECT_R;
          PH_G:    sel_d[2*i +: 2] = SELECT_G;
          PH_B:    sel_d[2*i +: 2] = SELECT_B;
          default: sel_d[2*i +: 2] = sel_q[2*i +: 2];
        endcase
      end
    end
  end

  always_comb begin
    raw_d = raw_q;
    if (phase_q == PH_CALC && cnt_q == '0) begin
      raw_d = '0;
      for (int unsigned i = 0; i < N_CH; i++) begin
        if (dbg_ch == DBG_W'(i)) raw_d = ch_cnt[i];
      end
    end
  end

  always_ff @(posedge clkus) begin
    if (!rst_n) begin
      phase_q <= PH_R;
      cnt_q   <= '0;
      sel_q   <= {N_CH{SELECT_OFF}};
      led_q   <= '0;
      raw_q   <= '0;
    end else begin
      phase_q <= phase_d;
      cnt_q   <= cnt_d;
      sel_q   <= sel_d;
      led_q   <= led_d;
      raw_q   <= raw_d;
    end
  end

  assign sel     = sel_q;
  assign led     = led_q;
  assign raw_cnt = raw_q;

  for (genvar gi = 0; gi < N_CH; gi++) begin : g_ch
    color_channel #(
      .PH_W      (PH_W),
      .PERIOD_US (PERIOD_US),
      .SETTLE_US (SETTLE_US),
      .CNT_W     (CNT_W),
      .MIN_CNT   (MIN_CNT),
      .RATIO_SH  (RATIO_SH),
      .STABLE_N  (STABLE_N)
    ) u_ch (
      .clkus       (clkus),
      .rst_n       (rst_n),
      .wave        (wave[gi]),
      .en          (en[gi]),
      .phase       (phase_q),
      .cnt         (cnt_q),
      .color       (color[2*gi +: 2]),
      .color_valid (color_valid[gi]),
      .counts      (ch_cnt[gi])
    );
  end

endmodule

// File: tb/tb_color_classifier_array.sv
// Frame-level bench: scripted and random edge counts per channel, checked
// against a count/classify/stability model built from the block's rules.
module tb_color_classifier_array;

  localparam int PER   = 200;
  localparam int SET   = 10;
  localparam int FR    = 4 * PER;
  localparam int PER_S = 2400;
  localparam int SAT   = 1023;

  logic        clkus = 1'b0;
  logic        rst_n;
  logic [1:0]  wave, en, led, color_valid;
  logic [3:0]  sel, color;
  logic [29:0] raw_cnt;
  logic [0:0]  dbg_ch;
  logic [1:0]  wave_s, en_s, led_s, valid_s;
  logic [3:0]  sel_s, color_s;
  logic [29:0] raw_s;
  logic [0:0]  dbg_s;

  always #5 clkus = ~clkus;

  color_classifier_array #(.N_CH(2), .PERIOD_US(PER), .SETTLE_US(SET)) dut (
    .clkus(clkus), .rst_n(rst_n), .wave(wave), .en(en), .sel(sel), .led(led),
    .color(color), .color_valid(color_valid), .raw_cnt(raw_cnt), .dbg_ch(dbg_ch)
  );

  color_classifier_array #(.N_CH(2), .PERIOD_US(PER_S), .SETTLE_US(SET)) dut_sat (
    .clkus(clkus), .rst_n(rst_n), .wave(wave_s), .en(en_s), .sel(sel_s), .led(led_s),
    .color(color_s), .color_valid(valid_s), .raw_cnt(raw_s), .dbg_ch(dbg_s)
  );

  int errors = 0;
  int checks = 0;

  int n_tab [2][3];
  bit pre_tab [2];
  int off_lo [2];
  int off_hi [2];
  int run_m [2];
  int last_m [2];
  int color_m [2];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // wave level driven at frame cycle k: pulses from cycle 20, optional pre-settle pulses
  function automatic bit w_at(input int ch, input int k);
    int p, c;
    if (k < 0) return 1'b0;
    p = k / PER;
    c = k % PER;
    if (p >= 3) return 1'b0;
    if (pre_tab[ch] && p == 0 && c < 6 && c % 2 == 0) return 1'b1;
    return (c >= 20) && (c < 20 + 2 * n_tab[ch][p]) && ((c - 20) % 2 == 0);
  endfunction

  function automatic bit en_at(input int ch, input int k);
    return !(k >= off_lo[ch] && k < off_hi[ch]);
  endfunction

  // rising edge seen two cycles after it is driven, counted if inside the window
  function automatic int model_cnt(input int ch, input int ph);
    int n = 0;
    for (int k = 0; k < FR - 2; k++) begin
      if (w_at(ch, k) && !w_at(ch, k - 1)) begin
        if ((k + 2) / PER == ph && (k + 2) % PER >= SET && en_at(ch, k + 2)) n++;
      end
    end
    return (n > SAT) ? SAT : n;
  endfunction

  function automatic int classify(input int r, input int g, input int b);
    if (r >= 16 && r - r / 4 > g && r - r / 4 > b) return 1;
    if (g >= 16 && g - g / 4 > r && g - g / 4 > b) return 2;
    if (b >= 16 && b - b / 4 > r && b - b / 4 > g) return 3;
    return 0;
  endfunction

  function automatic int sel_code(input int ph);
    case (ph)
      0:       return 0;
      1:       return 3;
      default: return 1;
    endcase
  endfunction

  task automatic set_ch(input int ch, input int r, input int g, input int b,
                        input int lo, input int hi, input bit pre);
    n_tab[ch][0] = r;
    n_tab[ch][1] = g;
    n_tab[ch][2] = b;
    off_lo[ch]   = lo;
    off_hi[ch]   = hi;
    pre_tab[ch]  = pre;
  endtask

  task automatic set_rand(input int ch);
    set_ch(ch, int'($urandom_range(80, 0)), int'($urandom_range(80, 0)),
           int'($urandom_range(80, 0)), FR, FR, 1'b0);
  endtask

  task automatic model_reset();
    for (int ch = 0; ch < 2; ch++) begin
      run_m[ch]   = 0;
      last_m[ch]  = 0;
      color_m[ch] = 0;
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_sel"},   32'(sel), 32'hF);
    check_eq({tag, "_led"},   32'(led), 0);
    check_eq({tag, "_color"}, 32'(color), 0);
    check_eq({tag, "_valid"}, 32'(color_valid), 0);
    check_eq({tag, "_raw"},   32'(raw_cnt), 0);
  endtask

  // one frame; called at the falling edge of frame cycle 0
  task automatic run_frame(input int fid, input int dbg, input int abort_k);
    int  rc [2];
    int  gc [2];
    int  bc [2];
    bit  eval [2];
    int  exp_raw;
    for (int ch = 0; ch < 2; ch++) begin
      rc[ch] = model_cnt(ch, 0);
      gc[ch] = model_cnt(ch, 1);
      bc[ch] = model_cnt(ch, 2);
      eval[ch] = 1'b1;
      for (int k = 0; k <= 3 * PER; k++) if (!en_at(ch, k)) eval[ch] = 1'b0;
      if (!en_at(ch, 3 * PER)) begin
        color_m[ch] = 0;
        run_m[ch]   = 0;
      end else if (eval[ch]) begin
        int cls = classify(rc[ch], gc[ch], bc[ch]);
        if (cls == last_m[ch]) run_m[ch] = (run_m[ch] >= 2) ? 2 : run_m[ch] + 1;
        else begin
          run_m[ch]  = 1;
          last_m[ch] = cls;
        end
        if (run_m[ch] >= 2) color_m[ch] = cls;
      end
    end
    exp_raw = (rc[dbg] << 20) | (gc[dbg] << 10) | bc[dbg];
    for (int k = 0; k < FR; k++) begin
      if (k == abort_k) begin
        rst_n = 1'b0;
        wave  = '0;
        @(negedge clkus);
        return;
      end
      if (k % PER == 100) begin
        for (int ch = 0; ch < 2; ch++) begin
          bit e = en_at(ch, k - 1);
          check_eq($sformatf("f%0d_k%0d_sel%0d", fid, k, ch), 32'(sel[2*ch +: 2]),
                   e ? 32'(sel_code(k / PER)) : 32'd3);
          check_eq($sformatf("f%0d_k%0d_led%0d", fid, k, ch), 32'(led[ch]), 32'(e));
        end
      end
      if (k == 3 * PER + 1) begin
        for (int ch = 0; ch < 2; ch++) begin
          check_eq($sformatf("f%0d_valid%0d", fid, ch), 32'(color_valid[ch]), 32'(eval[ch]));
          check_eq($sformatf("f%0d_color%0d", fid, ch), 32'(color[2*ch +: 2]), 32'(color_m[ch]));
        end
        check_eq($sformatf("f%0d_raw_ch%0d", fid, dbg), 32'(raw_cnt), 32'(exp_raw));
      end
      if (k == 3 * PER + 2)
        check_eq($sformatf("f%0d_valid_pulse", fid), 32'(color_valid), 0);
      for (int ch = 0; ch < 2; ch++) begin
        wave[ch] = w_at(ch, k);
        en[ch]   = en_at(ch, k);
      end
      dbg_ch = 1'(dbg);
      @(negedge clkus);
    end
  endtask

  initial begin
    rst_n  = 1'b0;
    wave   = '0;
    en     = '0;
    dbg_ch = '0;
    wave_s = '0;
    en_s   = 2'b01;
    dbg_s  = '0;
    repeat (3) @(negedge clkus);
    rst_n = 1'b1;
    check_reset_outputs("por");

    // long-period instance: 1100 R edges must saturate at 1023
    for (int k = 0; k <= 3 * PER_S + 1; k++) begin
      if (k == 3 * PER_S + 1) begin
        check_eq("sat_r", 32'(raw_s[29:20]), SAT);
        check_eq("sat_gb", 32'(raw_s[19:0]), 0);
        check_eq("sat_valid", 32'(valid_s), 1);
        check_eq("sat_color", 32'(color_s), 0);
        check_eq("sat_sel_off", 32'(sel_s[3:2]), 3);
      end
      wave_s[0] = (k < PER_S) && ((k < 6 && k % 2 == 0) ||
                  (k >= 20 && k < 20 + 2 * 1100 && (k - 20) % 2 == 0));
      @(negedge clkus);
    end

    rst_n = 1'b0;
    en_s  = '0;
    en    = 2'b11;
    repeat (2) @(negedge clkus);
    rst_n = 1'b1;
    model_reset();

    set_ch(0, 60, 10, 20, FR, FR, 1'b1);  set_ch(1, 8, 30, 8, FR, FR, 1'b0);  run_frame(1, 0, -1);
    set_ch(0, 60, 10, 20, FR, FR, 1'b0);  set_ch(1, 5, 5, 40, FR, FR, 1'b0);  run_frame(2, 1, -1);
    set_ch(0, 12, 3, 3, FR, FR, 1'b0);    set_ch(1, 5, 5, 40, FR, FR, 1'b0);  run_frame(3, 0, -1);
    set_ch(0, 40, 0, 31, FR, FR, 1'b0);   set_rand(1);                        run_frame(4, 0, -1);
    set_ch(0, 40, 0, 29, FR, FR, 1'b0);   set_rand(1);                        run_frame(5, 0, -1);
    set_ch(0, 50, 10, 10, 250, 260, 1'b0); set_rand(1);                       run_frame(6, 1, -1);
    set_ch(0, 50, 10, 10, 450, 700, 1'b0); set_rand(1);                       run_frame(7, 1, -1);
    for (int f = 8; f <= 12; f++) begin
      set_rand(0);
      set_rand(1);
      run_frame(f, int'($urandom_range(1, 0)), -1);
    end
    set_rand(0);
    set_rand(1);
    run_frame(13, 0, 2 * PER + 50);
    rst_n = 1'b1;
    check_reset_outputs("midreset");
    model_reset();
    set_ch(0, 30, 5, 5, FR, FR, 1'b0);  set_ch(1, 5, 30, 5, FR, FR, 1'b0);  run_frame(14, 0, -1);
    set_ch(0, 30, 5, 5, FR, FR, 1'b0);  set_ch(1, 5, 30, 5, FR, FR, 1'b0);  run_frame(15, 1, -1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
